regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 32×32 register file (`wren`/`rdin`/`rd_data_in`) between up to `NREQ` writeback sources (ALU, load unit, mul/div). It arbitrates with valid/ready handshakes, registers the granted write for one cycle, and drives the register file write port. It also keeps a per-register pending-write scoreboard that issue logic reads for RAW/WAW hazard stalls.

---
 rtl/regfile_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the single write port of the 32x32 register file between NREQ
// writeback sources. One requester is granted per cycle, its write is
// registered for one cycle and then driven onto wren/rdin/rd_data_in. A
// per-register pending-write scoreboard (busy) is kept for issue hazard checks.
//
// Handshake: requester i transfers on a cycle where req_valid[i] && req_ready[i]
// at the rising edge. req_ready is a combinational one-hot grant derived only
// from req_valid (and the priority pointer); it is never high without valid.
// A requester keeps valid/rd/data stable until it sees ready. The output stage
// never stalls, so some requester is granted every cycle any valid is high.
//
// Configuration macro: WB_ROUND_ROBIN_EN
//   defined   : round-robin priority, search starts after the last granted index
//   undefined : fixed priority, lowest index wins (no pointer register)
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_rd/req_data    per-requester write requests (packed vectors)
//   req_ready                    one-hot grant
//   issue_valid/issue_rd         destination of the instruction issuing now
//   flush                        synchronous clear of scoreboard and output stage
//   wren/rdin/rd_data_in         register file write port
//   busy                         pending-write scoreboard, bit 0 always 0
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic                 flush,
  output logic                 wren,
  output logic [4:0]           rdin,
  output logic [XLEN-1:0]      rd_data_in,
  output logic [31:0]          busy
);

  logic [NREQ-1:0] grant;
  logic            accept;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

`ifdef WB_ROUND_ROBIN_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;
  logic          found;

  // Two passes replace the modulo search: first the indices above the
  // pointer, then wrap around to the indices at or below it.
  always_comb begin
    grant   = '0;
    gnt_idx = ptr_q;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (PW'(i) > ptr_q)) begin
        grant[i] = 1'b1;
        gnt_idx  = PW'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (PW'(i) <= ptr_q)) begin
        grant[i] = 1'b1;
        gnt_idx  = PW'(i);
        found    = 1'b1;
      end
    end
  end

  // Pointer moves only on a real acceptance; flush cycles leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && !flush) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PW'(NREQ - 1);
    else        ptr_q <= ptr_d;
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  assign accept    = |grant;
  assign req_ready = grant;

  // Grant is one-hot, so a plain priority-free select is enough.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  logic            wren_q, wren_d;
  logic [4:0]      rdin_q, rdin_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [31:0]     busy_q, busy_d;

  // Output stage: a request granted during flush is consumed but dropped.
  // Writes to x0 are consumed without raising wren.
  always_comb begin
    wren_d = 1'b0;
    rdin_d = rdin_q;
    data_d = data_q;
    if (accept && !flush) begin
      wren_d = (sel_rd != 5'd0);
      rdin_d = sel_rd;
      data_d = sel_data;
    end
  end

  // Scoreboard: the set is applied after the clear so a same-cycle issue to
  // the register being written back keeps it pending.
  always_comb begin
    busy_d = busy_q;
    if (wren_q) busy_d[rdin_q] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q <= 1'b0;
      rdin_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      wren_q <= wren_d;
      rdin_q <= rdin_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign wren       = wren_q;
  assign rdin       = rdin_q;
  assign rd_data_in = data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the write port and scoreboard.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*5-1:0]    req_rd = '0;
  logic [NREQ*XLEN-1:0] req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 issue_valid = 1'b0;
  logic [4:0]           issue_rd = '0;
  logic                 flush = 1'b0;
  logic                 wren;
  logic [4:0]           rdin;
  logic [XLEN-1:0]      rd_data_in;
  logic [31:0]          busy;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .wren(wren), .rdin(rdin), .rd_data_in(rd_data_in), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  logic [NREQ-1:0] last_ready = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic            m_wren = 1'b0;
  logic [4:0]      m_rdin = '0;
  logic [XLEN-1:0] m_data = '0;
  logic [31:0]     m_busy = '0;
  int              m_ptr = NREQ - 1;

  // Which requester must win given the valids and the last granted index.
  function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
`ifdef WB_ROUND_ROBIN_EN
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (v[idx]) return idx;
    end
`else
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    logic [31:0] b;
    logic [4:0] grd;
    if (!rst_n) begin
      m_wren <= 1'b0;
      m_rdin <= '0;
      m_data <= '0;
      m_busy <= '0;
      m_ptr  <= NREQ - 1;
    end else begin
      g = exp_grant(req_valid, m_ptr);
      b = m_busy;
      if (m_wren) b[m_rdin] = 1'b0;
      if (issue_valid && issue_rd != 0) b[issue_rd] = 1'b1;
      if (flush) b = '0;
      m_busy <= b;
      if (g >= 0 && !flush) begin
        grd = req_rd[5*g +: 5];
        m_wren <= (grd != 0);
        m_rdin <= grd;
        m_data <= req_data[XLEN*g +: XLEN];
        m_ptr  <= g;
      end else begin
        m_wren <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [XLEN-1:0] exp_q[$];
    g = exp_grant(req_valid, m_ptr);
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    exp_q.push_back(m_data);
    chk("ready", 64'(req_ready), 64'(exp_rdy));
    chk("wren", 64'(wren), 64'(m_wren));
    chk("busy", 64'(busy), 64'(m_busy));
    if (m_wren) begin
      chk("rdin", 64'(rdin), 64'(m_rdin));
      chk("data", 64'(rd_data_in), 64'(exp_q.pop_front()));
    end else begin
      chk("rdin_hold", 64'(rdin), 64'(m_rdin));
      chk("data_hold", 64'(rd_data_in), 64'(exp_q.pop_front()));
    end
    last_ready = req_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid   = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    flush       = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
    req_valid[i] = 1'b1;
    req_rd[5*i +: 5] = rd;
    req_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    // Reset with random inputs applied.
    req_valid   = NREQ'($urandom);
    req_rd      = (NREQ*5)'($urandom);
    req_data    = {$urandom, $urandom, $urandom};
    issue_valid = 1'b1;
    issue_rd    = 5'($urandom_range(1, 31));
    flush       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wren", 64'(wren), 64'(0));
    chk("rst_rdin", 64'(rdin), 64'(0));
    chk("rst_data", 64'(rd_data_in), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    step(); rst_n = 1'b1; idle();

    // First write after reset.
    step(); set_req(0, 5'd5, 32'hDEADBEEF);
    @(negedge clk); chk("first_ready", 64'(req_ready), 64'(3'b001));
    step(); idle();
    @(negedge clk);
    chk("first_wren", 64'(wren), 64'(1));
    chk("first_rdin", 64'(rdin), 64'(5));
    chk("first_data", 64'(rd_data_in), 64'(32'hDEADBEEF));

    // Scoreboard set / clear timing.
    step(); issue(5'd7);
    step(); idle();
    @(negedge clk); chk("sb_set7", 64'(busy[7]), 64'(1));
    step();
    step(); set_req(2, 5'd7, 32'hCAFE0007);
    @(negedge clk); chk("sb_ready2", 64'(req_ready), 64'(3'b100));
    step(); idle();
    @(negedge clk);
    chk("sb_wren7", 64'(wren), 64'(1));
    chk("sb_rdin7", 64'(rdin), 64'(7));
    chk("sb_busy7_held", 64'(busy[7]), 64'(1));
    step();
    @(negedge clk); chk("sb_clr7", 64'(busy[7]), 64'(0));

    // Same-cycle set and clear on x9: set wins.
    step(); issue(5'd9);
    step(); idle(); set_req(1, 5'd9, 32'h99);
    step(); idle(); issue(5'd9);
    @(negedge clk);
    chk("sw_wren9", 64'(wren), 64'(1));
    chk("sw_rdin9", 64'(rdin), 64'(9));
    step(); idle();
    @(negedge clk); chk("sw_busy9", 64'(busy), 64'(32'h0000_0200));

    // x0 handling.
    step(); issue(5'd0);
    step(); idle();
    @(negedge clk); chk("x0_busy", 64'(busy), 64'(32'h0000_0200));
    step(); set_req(0, 5'd0, 32'h1234);
    @(negedge clk); chk("x0_ready", 64'(req_ready), 64'(3'b001));
    step(); idle();
    @(negedge clk); chk("x0_wren", 64'(wren), 64'(0));

    // Flush with an accepted request in the same cycle.
    step(); issue(5'd8);
    step(); issue(5'd10);
    step(); issue(5'd11);
    step(); idle();
    @(negedge clk); chk("fl_pre_busy", 64'(busy), 64'(32'h0000_0F00));
    step(); set_req(0, 5'd4, 32'h44); flush = 1'b1;
    @(negedge clk); chk("fl_ready", 64'(req_ready), 64'(3'b001));
    step(); idle();
    @(negedge clk);
    chk("fl_busy", 64'(busy), 64'(0));
    chk("fl_wren", 64'(wren), 64'(0));

    // Asynchronous reset while a write is on the port.
    step(); set_req(0, 5'd6, 32'h66); issue(5'd12);
    step(); idle();
    @(negedge clk); chk("ar_wren_pre", 64'(wren), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wren", 64'(wren), 64'(0));
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_rdin", 64'(rdin), 64'(0));
    step(); rst_n = 1'b1;

    // Contention from a fresh pointer.
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'h100 + i);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef WB_ROUND_ROBIN_EN
      chk("cont_rr", 64'(req_ready), 64'(3'b001 << (k % 3)));
`else
      chk("cont_fixed", 64'(req_ready), 64'(3'b001));
`endif
      step();
    end
    idle();

    // Randomized traffic, requesters hold until accepted.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !last_ready[i])) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_rd[5*i +: 5] = 5'($urandom_range(0, 31));
          req_data[XLEN*i +: XLEN] = $urandom;
        end
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 31));
      flush       = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    step(); idle();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
